bus_port_ctrl: RTL and testbench

Parametrised, clocked successor to the combinational bus-control logic. It serves an asynchronous host strobe bus (CS_n/RD_n/WR_n, address, data) and fronts NUM_PORTS internal data registers. Strobes are synchronised into the system clock, and a small FSM sequences reads and writes. Per-port write/read permits gate each access, and sticky error flags record faults.

---
 rtl/bus_ctrl_pkg.sv | 15 +
 rtl/strobe_sync.sv | 21 ++
 rtl/bus_port_ctrl.sv | 149 ++++++++++++++
 tb/tb_bus_port_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared FSM state encoding and error-bit indices for the host bus port controller
package bus_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACT,
        WR_ACT,
        TURN,
        HOLD
    } state_t;

    localparam int ERR_CONFLICT = 0;
    localparam int ERR_DENIED   = 1;

endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: multi-stage synchroniser for an active-low host strobe, resetting to inactive (1)
module strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // shift the asynchronous strobe through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bus_port_ctrl.sv
// bus_port_ctrl: clocked host strobe bus front-end sequencing permitted reads/writes to internal port registers
module bus_port_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                NUM_PORTS   = 4,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    localparam int               ADDR_W      = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          CS_n,
    input  logic                          RD_n,
    input  logic                          WR_n,
    input  logic [ADDR_W-1:0]             A,
    input  logic [DATA_W-1:0]             D_in,
    output logic [DATA_W-1:0]             D_out,
    output logic                          D_oe,
    input  logic [NUM_PORTS-1:0]          IWR,
    input  logic [NUM_PORTS-1:0]          IRD,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_in,
    output logic [NUM_PORTS*DATA_W-1:0]   port_q,
    output logic [NUM_PORTS-1:0]          wr_pulse,
    output logic [NUM_PORTS-1:0]          rd_pulse,
    output logic [1:0]                    err,
    input  logic                          err_clr
);

    logic cs_sync, rd_sync, wr_sync, primed_n, rd_s, wr_s, a_ok, r_ok;
    logic d_oe, armed_q, armed_d;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, dout_q, dout_d;
    logic [DATA_W-1:0] pin [NUM_PORTS];
    logic [DATA_W-1:0] ports_q [NUM_PORTS];
    logic [DATA_W-1:0] ports_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
    logic [1:0] err_q, err_d;

    strobe_sync #(.STAGES(SYNC_STAGES)) u_cs (.clk(clk), .rst_n(rst_n), .d_i(CS_n), .q_o(cs_sync));
    strobe_sync #(.STAGES(SYNC_STAGES)) u_rd (.clk(clk), .rst_n(rst_n), .d_i(RD_n), .q_o(rd_sync));
    strobe_sync #(.STAGES(SYNC_STAGES)) u_wr (.clk(clk), .rst_n(rst_n), .d_i(WR_n), .q_o(wr_sync));
    // falls once the strobe chains hold real samples rather than their reset value
    strobe_sync #(.STAGES(SYNC_STAGES)) u_pr (.clk(clk), .rst_n(rst_n), .d_i(1'b0), .q_o(primed_n));

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        assign pin[k] = port_in[k*DATA_W +: DATA_W];
        assign port_q[k*DATA_W +: DATA_W] = ports_q[k];
    end

    assign rd_s  = !cs_sync && !rd_sync;
    assign wr_s  = !cs_sync && !wr_sync;
    assign a_ok  = int'(A) < NUM_PORTS;
    assign r_ok  = int'(addr_q) < NUM_PORTS;
    // a strobe held low across reset must be released before any new access is accepted
    assign armed_d = armed_q || (!primed_n && !rd_s && !wr_s);

    // next-state, access bookkeeping, commit and error logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        dout_d     = dout_q;
        ports_d    = ports_q;
        wr_pulse_d = '0;
        rd_pulse_d = '0;
        err_d      = err_clr ? 2'b00 : err_q;
        d_oe       = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && rd_s && wr_s) begin
                    state_d             = HOLD;
                    err_d[ERR_CONFLICT] = 1'b1;
                end else if (armed_q && rd_s) begin
                    state_d = RD_ACT;
                    addr_d  = A;
                    dout_d  = a_ok ? pin[A] : '0;
                    if (!(a_ok && IRD[A])) err_d[ERR_DENIED] = 1'b1;
                end else if (armed_q && wr_s) begin
                    state_d = WR_ACT;
                    addr_d  = A;
                    data_d  = D_in;
                end
            end
            RD_ACT: begin
                d_oe = r_ok && IRD[addr_q] && !wr_s;
                if (wr_s) begin
                    state_d             = HOLD;
                    err_d[ERR_CONFLICT] = 1'b1;
                end else if (!rd_s) begin
                    state_d = TURN;
                    if (r_ok && IRD[addr_q]) rd_pulse_d[addr_q] = 1'b1;
                end
            end
            WR_ACT: begin
                addr_d = A;
                data_d = D_in;
                if (rd_s) begin
                    state_d             = HOLD;
                    err_d[ERR_CONFLICT] = 1'b1;
                end else if (!wr_s) begin
                    state_d = IDLE;
                    if (r_ok && IWR[addr_q]) begin
                        ports_d[addr_q]    = data_q;
                        wr_pulse_d[addr_q] = 1'b1;
                    end else begin
                        err_d[ERR_DENIED] = 1'b1;
                    end
                end
            end
            TURN:    state_d = IDLE;
            HOLD:    state_d = (!rd_s && !wr_s) ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            dout_q     <= '0;
            ports_q    <= '{default: RESET_VAL};
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            dout_q     <= dout_d;
            ports_q    <= ports_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            err_q      <= err_d;
        end
    end

    assign D_out    = dout_q;
    assign D_oe     = d_oe;
    assign wr_pulse = wr_pulse_q;
    assign rd_pulse = rd_pulse_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bus_port_ctrl.sv
// tb_bus_port_ctrl: directed self-checking bench for bus_port_ctrl (4-port and 3-port instances)
module tb_bus_port_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, clr = 1'b0;
    logic [1:0]  a = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        doe;
    logic [3:0]  iwr = 4'hF, ird = 4'hF;
    logic [31:0] pin = '0;
    logic [31:0] pq;
    logic [3:0]  wp, rp;
    logic [1:0]  er;

    logic        cs3_n = 1'b1, rd3_n = 1'b1, wr3_n = 1'b1, clr3 = 1'b0;
    logic [1:0]  a3 = '0;
    logic [7:0]  din3 = '0;
    logic [7:0]  dout3;
    logic        doe3;
    logic [2:0]  iwr3 = 3'b111, ird3 = 3'b111;
    logic [23:0] pin3 = 24'hABCDEF;
    logic [23:0] pq3;
    logic [2:0]  wp3, rp3;
    logic [1:0]  er3;

    always #5 clk = ~clk;

    bus_port_ctrl #(.DATA_W(8), .NUM_PORTS(4), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .CS_n(cs_n), .RD_n(rd_n), .WR_n(wr_n), .A(a), .D_in(din),
        .D_out(dout), .D_oe(doe), .IWR(iwr), .IRD(ird), .port_in(pin), .port_q(pq),
        .wr_pulse(wp), .rd_pulse(rp), .err(er), .err_clr(clr)
    );

    bus_port_ctrl #(.DATA_W(8), .NUM_PORTS(3), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut3 (
        .clk(clk), .rst_n(rst_n), .CS_n(cs3_n), .RD_n(rd3_n), .WR_n(wr3_n), .A(a3), .D_in(din3),
        .D_out(dout3), .D_oe(doe3), .IWR(iwr3), .IRD(ird3), .port_in(pin3), .port_q(pq3),
        .wr_pulse(wp3), .rd_pulse(rp3), .err(er3), .err_clr(clr3)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        chk("rst_port_q", 64'(pq), 64'h0);
        chk("rst_d_out", 64'(dout), 64'h0);
        chk("rst_d_oe", 64'(doe), 64'h0);
        chk("rst_pulses", 64'({wp, rp}), 64'h0);
        chk("rst_err", 64'(er), 64'h0);
        tick(2);
        rst_n = 1'b1;
        cs_n  = 1'b0;
        tick(5);

        // write 0xA5 to port 2
        a = 2'd2; din = 8'hA5; wr_n = 1'b0;
        tick(6);
        wr_n = 1'b1;
        tick(2);
        chk("wr_not_yet", 64'(pq), 64'h0);
        tick(1);
        chk("wr_commit", 64'(pq), 64'h00A50000);
        chk("wr_pulse", 64'(wp), 64'h4);
        tick(1);
        chk("wr_pulse_end", 64'(wp), 64'h0);
        chk("wr_err", 64'(er), 64'h0);

        // read port 1 with snapshot held against port_in change
        pin[8 +: 8] = 8'h3C; a = 2'd1; rd_n = 1'b0;
        tick(2);
        chk("rd_oe_early", 64'(doe), 64'h0);
        tick(1);
        chk("rd_oe", 64'(doe), 64'h1);
        chk("rd_data", 64'(dout), 64'h3C);
        pin[8 +: 8] = 8'hFF;
        tick(2);
        chk("rd_snapshot", 64'(dout), 64'h3C);
        tick(3);
        rd_n = 1'b1;
        tick(2);
        chk("rd_oe_hold", 64'(doe), 64'h1);
        tick(1);
        chk("rd_turn_oe", 64'(doe), 64'h0);
        chk("rd_pulse", 64'(rp), 64'h2);
        tick(1);
        chk("rd_pulse_end", 64'(rp), 64'h0);
        chk("rd_idle_oe", 64'(doe), 64'h0);

        // write denied by permit
        iwr = 4'b1110; a = 2'd0; din = 8'h77; wr_n = 1'b0;
        tick(5);
        wr_n = 1'b1;
        tick(3);
        chk("deny_port_q", 64'(pq), 64'h00A50000);
        chk("deny_pulse", 64'(wp), 64'h0);
        chk("deny_err", 64'(er), 64'h2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("err_clr", 64'(er), 64'h0);

        // RD and WR together
        iwr = 4'hF; a = 2'd3; din = 8'h66; rd_n = 1'b0; wr_n = 1'b0;
        tick(3);
        chk("conf_err", 64'(er), 64'h1);
        for (int i = 0; i < 4; i++) begin
            chk("conf_oe", 64'(doe), 64'h0);
            tick(1);
        end
        rd_n = 1'b1; wr_n = 1'b1;
        tick(4);
        chk("conf_port_q", 64'(pq), 64'h00A50000);
        chk("conf_pulses", 64'({wp, rp}), 64'h0);
        chk("conf_err_sticky", 64'(er), 64'h1);
        pin[16 +: 8] = 8'h5A; a = 2'd2; rd_n = 1'b0;
        tick(3);
        chk("conf_idle_oe", 64'(doe), 64'h1);
        chk("conf_idle_data", 64'(dout), 64'h5A);
        rd_n = 1'b1;
        tick(4);

        // reset during a write
        a = 2'd3; din = 8'hCC; wr_n = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_port_q", 64'(pq), 64'h0);
        chk("mid_rst_d_out", 64'(dout), 64'h0);
        chk("mid_rst_d_oe", 64'(doe), 64'h0);
        chk("mid_rst_err", 64'(er), 64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_port_q", 64'(pq), 64'h0);
        wr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("post_rst_no_commit", 64'({pq, wp}), 64'h0);
        end
        a = 2'd0; din = 8'h11; wr_n = 1'b0;
        tick(4);
        wr_n = 1'b1;
        tick(3);
        chk("post_rst_write", 64'(pq), 64'h00000011);
        chk("post_rst_pulse", 64'(wp), 64'h1);

        // three-port instance, out-of-range address
        cs3_n = 1'b0;
        tick(3);
        a3 = 2'd3; din3 = 8'h99; wr3_n = 1'b0;
        tick(5);
        wr3_n = 1'b1;
        tick(3);
        chk("oor_wr_port_q", 64'(pq3), 64'h0);
        chk("oor_wr_pulse", 64'(wp3), 64'h0);
        chk("oor_wr_err", 64'(er3), 64'h2);
        clr3 = 1'b1;
        tick(1);
        clr3 = 1'b0;
        chk("oor_err_clr", 64'(er3), 64'h0);
        rd3_n = 1'b0;
        tick(3);
        chk("oor_rd_oe", 64'(doe3), 64'h0);
        chk("oor_rd_data", 64'(dout3), 64'h0);
        chk("oor_rd_err", 64'(er3), 64'h2);
        tick(2);
        chk("oor_rd_oe_late", 64'(doe3), 64'h0);
        rd3_n = 1'b1;
        tick(3);
        chk("oor_rd_pulse", 64'(rp3), 64'h0);
        tick(1);
        a3 = 2'd2; din3 = 8'h42; wr3_n = 1'b0;
        tick(5);
        wr3_n = 1'b1;
        tick(3);
        chk("p3_wr_port_q", 64'(pq3), 64'h420000);
        chk("p3_wr_pulse", 64'(wp3), 64'h4);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
